// File: rtl/alu_operand_pipe.sv
// Registered ALU operand former with a 2-entry skid FIFO between decode and execute.
// Optional EX/MEM forwarding into rs/rt at push time is enabled by defining ALU_OPD_FWD_EN.
module alu_operand_pipe #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] rsVal,
  input  logic [DATA_W-1:0] rtVal,
  input  logic              ex_wr_en,
  input  logic [2:0]        ex_wr_reg,
  input  logic [DATA_W-1:0] ex_wr_data,
  input  logic              mem_wr_en,
  input  logic [2:0]        mem_wr_reg,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic              out_illegal
);

  generate
    if (DEPTH != 2 || DATA_W < 16) begin : g_bad_param
      $error("alu_operand_pipe: DEPTH must be 2 and DATA_W must be >= 16");
    end
  endgenerate

  // Valid/ready: a beat transfers on a rising edge where valid and ready are both high.
  logic [1:0]        count;
  logic              init_done;
  logic [DATA_W-1:0] tail_a;
  logic [DATA_W-1:0] tail_b;
  logic              tail_ill;
  logic [DATA_W-1:0] rs_opd;
  logic [DATA_W-1:0] rt_opd;
  logic [DATA_W-1:0] new_b;
  logic              new_ill;
  logic              push;
  logic              pop;
  logic [4:0]        op5;
  logic [2:0]        rs_idx;
  logic [2:0]        rt_idx;

  assign op5    = instr[15:11];
  assign rs_idx = instr[10:8];
  assign rt_idx = instr[7:5];

  assign in_ready  = init_done && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ALU_OPD_FWD_EN
  always_comb begin
    rs_opd = rsVal;
    rt_opd = rtVal;
    if (ex_wr_en && ex_wr_reg == rs_idx)
      rs_opd = ex_wr_data;
    else if (mem_wr_en && mem_wr_reg == rs_idx)
      rs_opd = mem_wr_data;
    if (ex_wr_en && ex_wr_reg == rt_idx)
      rt_opd = ex_wr_data;
    else if (mem_wr_en && mem_wr_reg == rt_idx)
      rt_opd = mem_wr_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_wr_en, ex_wr_reg, ex_wr_data, mem_wr_en, mem_wr_reg, mem_wr_data};
  assign rs_opd = rsVal;
  assign rt_opd = rtVal;
`endif

  always_comb begin
    new_b   = '0;
    new_ill = 1'b0;
    casez (op5)
      5'b11011, 5'b111??:
        new_b = rt_opd;
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011:
        new_b = {{(DATA_W-5){instr[4]}}, instr[4:0]};
      5'b01010, 5'b01011, 5'b101??:
        new_b = {{(DATA_W-5){1'b0}}, instr[4:0]};
      5'b01100, 5'b01101, 5'b01111, 5'b11000, 5'b00101, 5'b00111:
        new_b = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      5'b10010:
        new_b = {{(DATA_W-8){1'b0}}, instr[7:0]};
      5'b00100, 5'b00110:
        new_b = {{(DATA_W-11){instr[10]}}, instr[10:0]};
      5'b11001:
        new_b = {{(DATA_W-1){1'b0}}, 1'b1};
      5'b11010: begin
        new_b   = {{(DATA_W-1){1'b0}}, 1'b1};
        new_ill = 1'b1;
      end
      default:
        new_b = '0;
    endcase
  end

  // Head entry lives directly in the output registers; tail is the skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      init_done   <= 1'b0;
      opA         <= '0;
      opB         <= '0;
      out_illegal <= 1'b0;
      tail_a      <= '0;
      tail_b      <= '0;
      tail_ill    <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (flush) begin
        count       <= 2'd0;
        opA         <= '0;
        opB         <= '0;
        out_illegal <= 1'b0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              opA         <= rs_opd;
              opB         <= new_b;
              out_illegal <= new_ill;
              count       <= 2'd1;
            end else begin
              tail_a   <= rs_opd;
              tail_b   <= new_b;
              tail_ill <= new_ill;
              count    <= 2'd2;
            end
          end
          2'b01: begin
            if (count == 2'd2) begin
              opA         <= tail_a;
              opB         <= tail_b;
              out_illegal <= tail_ill;
              count       <= 2'd1;
            end else begin
              count <= 2'd0;
            end
          end
          2'b11: begin
            // Only reachable at count==1: the head is replaced in place.
            opA         <= rs_opd;
            opB         <= new_b;
            out_illegal <= new_ill;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_pipe.sv
// Scoreboard bench for alu_operand_pipe: a decode model predicts each accepted beat,
// a negedge monitor pops and compares whenever the head is consumed.
module tb_alu_operand_pipe;
  localparam int DATA_W = 16;
  localparam int W      = 2 * DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] rsVal;
  logic [DATA_W-1:0] rtVal;
  logic              ex_wr_en;
  logic [2:0]        ex_wr_reg;
  logic [DATA_W-1:0] ex_wr_data;
  logic              mem_wr_en;
  logic [2:0]        mem_wr_reg;
  logic [DATA_W-1:0] mem_wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              out_illegal;

  alu_operand_pipe #(.DATA_W(DATA_W), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rsVal(rsVal), .rtVal(rtVal),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opA(opA), .opB(opB), .out_illegal(out_illegal)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];
  logic armed = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Reference model: operand pair from the decode table, with optional forwarding.
  function automatic logic [W-1:0] model(
    input logic [15:0] ins, input logic [DATA_W-1:0] rsv, input logic [DATA_W-1:0] rtv,
    input logic exen, input logic [2:0] exr, input logic [DATA_W-1:0] exd,
    input logic memen, input logic [2:0] memr, input logic [DATA_W-1:0] memd);
    int op, rs, rt;
    logic [DATA_W-1:0] a, t, b;
    logic ill;
    op = int'(ins[15:11]);
    rs = int'(ins[10:8]);
    rt = int'(ins[7:5]);
    a = rsv;
    t = rtv;
`ifdef ALU_OPD_FWD_EN
    if (memen && int'(memr) == rs) a = memd;
    if (exen && int'(exr) == rs) a = exd;
    if (memen && int'(memr) == rt) t = memd;
    if (exen && int'(exr) == rt) t = exd;
`endif
    ill = (op == 26);
    if (op == 27 || op >= 28) b = t;
    else if (op inside {8, 9, 16, 17, 19}) b = DATA_W'(sx(int'(ins[4:0]), 5));
    else if (op inside {10, 11, 20, 21, 22, 23}) b = DATA_W'(int'(ins[4:0]));
    else if (op inside {12, 13, 15, 24, 5, 7}) b = DATA_W'(sx(int'(ins[7:0]), 8));
    else if (op == 18) b = DATA_W'(int'(ins[7:0]));
    else if (op == 4 || op == 6) b = DATA_W'(sx(int'(ins[10:0]), 11));
    else if (op == 25 || op == 26) b = DATA_W'(1);
    else b = '0;
    return {ill, b, a};
  endfunction

  // Monitor / scoreboard: DUT state is stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 1'b0;
        exp_q.delete();
      end else begin
        int sz;
        logic mready;
        sz = exp_q.size();
        mready = armed && (sz < 2);
        check("out_valid", W'(out_valid), W'(sz != 0));
        check("in_ready", W'(in_ready), W'(mready));
        if (flush) begin
          exp_q.delete();
        end else begin
          if (out_ready && sz != 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("head", {out_illegal, opB, opA}, e);
          end
          if (in_valid && mready)
            exp_q.push_back(model(instr, rsVal, rtVal, ex_wr_en, ex_wr_reg, ex_wr_data,
                                  mem_wr_en, mem_wr_reg, mem_wr_data));
        end
        armed = 1'b1;
      end
    end
  end

  // Driver tasks
  task automatic set_beat(input logic [15:0] ins, input logic [DATA_W-1:0] rsv,
                          input logic [DATA_W-1:0] rtv);
    in_valid = 1'b1;
    instr    = ins;
    rsVal    = rsv;
    rtVal    = rtv;
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic send(input logic [15:0] ins, input logic [DATA_W-1:0] rsv,
                      input logic [DATA_W-1:0] rtv);
    set_beat(ins, rsv, rtv);
    wait_accept();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rsVal = '0; rtVal = '0;
    ex_wr_en = 1'b0; ex_wr_reg = '0; ex_wr_data = '0;
    mem_wr_en = 1'b0; mem_wr_reg = '0; mem_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_opA", W'(opA), W'(0));
    check("rst_opB", W'(opB), W'(0));
    check("rst_illegal", W'(out_illegal), W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADDI r1,r2,-3 with rsVal=5: one-cycle latency, sign-extended imm
    out_ready = 1'b1;
    send(16'h415D, 16'd5, 16'd9);
    in_valid = 1'b0;
    check("addi_valid", W'(out_valid), W'(1));
    check("addi_opA", W'(opA), W'(16'd5));
    check("addi_opB", W'(opB), W'(16'hFFFD));

    // Unimplemented opcode 11010
    send(16'hD000, 16'h1234, 16'h0);
    in_valid = 1'b0;
    check("illegal_flag", W'(out_illegal), W'(1));
    check("illegal_opB", W'(opB), W'(16'd1));
    idle(3);

    // Immediate classes: zext5, sext8, zext8, sext11, const 1, const 0, R-type
    send(16'h501F, 16'h0101, 16'h0202);
    send(16'h6080, 16'h0303, 16'h0404);
    send(16'h90F0, 16'h0505, 16'h0606);
    send(16'h2400, 16'h0707, 16'h0808);
    send(16'hC8FF, 16'h0909, 16'h0A0A);
    send(16'h70FF, 16'h0B0B, 16'h0C0C);
    send(16'hDA60, 16'h0D0D, 16'hBEEF);
    idle(4);

    // Back-pressure: third beat stalls, then all drain in order
    out_ready = 1'b0;
    send(16'h4101, 16'h0011, 16'h0);
    send(16'h4102, 16'h0022, 16'h0);
    set_beat(16'h4103, 16'h0033, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("stall_in_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    wait_accept();
    idle(4);

    // Forwarding priority on rs=2 (ignored when forwarding is compiled out)
    ex_wr_en = 1'b1; ex_wr_reg = 3'd2; ex_wr_data = 16'hAAAA;
    mem_wr_en = 1'b1; mem_wr_reg = 3'd2; mem_wr_data = 16'h5555;
    send(16'hDA40, 16'h1111, 16'h2222);
    ex_wr_en = 1'b0;
    send(16'hDA40, 16'h1111, 16'h2222);
    mem_wr_reg = 3'd0;
    send(16'hD800, 16'h3333, 16'h4444);
    mem_wr_en = 1'b0;
    idle(4);

    // Flush at count=2 with an input beat pending
    out_ready = 1'b0;
    send(16'h4105, 16'h0055, 16'h0);
    send(16'h4106, 16'h0066, 16'h0);
    set_beat(16'h4107, 16'h0077, 16'h0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", W'(out_valid), W'(0));
    out_ready = 1'b1;
    idle(3);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      instr       = 16'($urandom);
      rsVal       = DATA_W'($urandom);
      rtVal       = DATA_W'($urandom);
      ex_wr_en    = $urandom_range(0, 1) == 1;
      ex_wr_reg   = 3'($urandom_range(0, 7));
      ex_wr_data  = DATA_W'($urandom);
      mem_wr_en   = $urandom_range(0, 1) == 1;
      mem_wr_reg  = 3'($urandom_range(0, 7));
      mem_wr_data = DATA_W'($urandom);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    ex_wr_en = 1'b0;
    mem_wr_en = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset while stalled with a full FIFO
    out_ready = 1'b0;
    send(16'h4108, 16'h0088, 16'h0);
    send(16'h4109, 16'h0099, 16'h0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("areset_valid", W'(out_valid), W'(0));
    check("areset_opA", W'(opA), W'(0));
    check("areset_opB", W'(opB), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h5A0C, 16'h00CC, 16'h0);
    send(16'h4A1D, 16'h00DD, 16'h0);
    idle(6);

    check("drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
